// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: owns the PC, fetches one word at a time over a
// req/ready + rvalid port, holds it for the decoder until retire, then steers the PC.
module fetch_unit #(
  parameter int                ADDR_WIDTH = 32,
  parameter logic [31:0]       RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic                  imem_rvalid,
  input  logic [31:0]           imem_rdata,
  output logic [31:0]           instr,
  output logic                  instr_valid,
  output logic [5:0]            opcode,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] pc_plus4,
  input  logic                  branch,
  input  logic                  jump,
  input  logic                  zero,
  input  logic                  retire,
  output logic [31:0]           retired_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_EXEC = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] PC_STEP = 32'd4;

  state_t                  state_r;
  logic [ADDR_WIDTH-1:0]   pc_r;
  logic [31:0]             instr_r;
  logic                    instr_valid_r;
  logic                    imem_req_r;
  logic [31:0]             retired_count_r;
  logic [ADDR_WIDTH-1:0]   pc_plus4_s;
  logic [ADDR_WIDTH-1:0]   next_pc_s;

  // Jump keeps the 256 MB region of the fall-through address; it wins over branch.
  function automatic logic [31:0] calc_next_pc(
    input logic [31:0] seq_pc,
    input logic [31:0] ins,
    input logic        br,
    input logic        jp,
    input logic        z
  );
    logic [31:0] target;
    if (jp) begin
      target = {seq_pc[31:28], ins[25:0], 2'b00};
    end else if (br && z) begin
      target = seq_pc + {{14{ins[15]}}, ins[15:0], 2'b00};
    end else begin
      target = seq_pc;
    end
    return target;
  endfunction

  // Fall-through and redirect targets for the held instruction.
  always_comb begin
    pc_plus4_s = pc_r + PC_STEP;
    next_pc_s  = calc_next_pc(pc_plus4_s, instr_r, branch, jump, zero);
  end

  // Fetch sequencer; every output it drives is a register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= ST_IDLE;
      pc_r            <= RESET_PC;
      instr_r         <= 32'h0000_0000;
      instr_valid_r   <= 1'b0;
      imem_req_r      <= 1'b0;
      retired_count_r <= 32'h0000_0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r    <= ST_REQ;
          imem_req_r <= 1'b1;
        end
        ST_REQ: begin
          if (imem_ready) begin
            state_r    <= ST_WAIT;
            imem_req_r <= 1'b0;
          end else begin
            state_r    <= ST_REQ;
            imem_req_r <= 1'b1;
          end
        end
        ST_WAIT: begin
          imem_req_r <= 1'b0;
          if (imem_rvalid) begin
            state_r       <= ST_EXEC;
            instr_r       <= imem_rdata;
            instr_valid_r <= 1'b1;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_EXEC: begin
          if (retire) begin
            state_r         <= ST_REQ;
            imem_req_r      <= 1'b1;
            instr_valid_r   <= 1'b0;
            pc_r            <= next_pc_s;
            retired_count_r <= retired_count_r + 32'd1;
          end else begin
            state_r    <= ST_EXEC;
            imem_req_r <= 1'b0;
          end
        end
        default: begin
          state_r       <= ST_IDLE;
          imem_req_r    <= 1'b0;
          instr_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req      = imem_req_r;
  assign imem_addr     = {pc_r[ADDR_WIDTH-1:2], 2'b00};
  assign instr         = instr_r;
  assign instr_valid   = instr_valid_r;
  assign opcode        = instr_r[31:26];
  assign pc            = pc_r;
  assign pc_plus4      = pc_plus4_s;
  assign retired_count = retired_count_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a TB-side memory drives the port with random
// stalls and the expected PC stream comes from a plain-arithmetic reference model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [5:0]  opcode;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        branch = 1'b0;
  logic        jump = 1'b0;
  logic        zero = 1'b0;
  logic        retire = 1'b0;
  logic [31:0] retired_count;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] m_pc     = 32'h0;
  logic [31:0] m_count  = 32'h0;

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .opcode(opcode),
    .pc(pc), .pc_plus4(pc_plus4),
    .branch(branch), .jump(jump), .zero(zero), .retire(retire),
    .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  // MIPS next-PC semantics in plain arithmetic, independent of any bit-packing.
  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] w,
                                           input logic br, input logic jp, input logic z);
    logic [31:0] seq;
    int          off;
    seq = cur + 32'd4;
    if (jp) return (seq & 32'hF000_0000) | ((w & 32'h03FF_FFFF) * 32'd4);
    if (br && z) begin
      off = int'(w & 32'h0000_FFFF);
      if (off >= 32768) off = off - 65536;
      return seq + 32'(off * 4);
    end
    return seq;
  endfunction

  // One full fetch/execute/retire round trip with the given stalls and decode inputs.
  task automatic fetch_one(input logic [31:0] word, input logic br, input logic jp,
                           input logic z, input int rdy_dly, input int rv_dly, input int ex_dly);
    int n;
    n = 0;
    while (!imem_req && n < 8) begin
      @(negedge clk);
      n++;
    end
    check_eq("req_seen", {31'd0, imem_req}, 32'd1);
    check_eq("fetch_addr", imem_addr, m_pc);
    for (int i = 0; i < rdy_dly; i++) begin
      imem_ready  = 1'b0;
      imem_rvalid = 1'($urandom_range(0, 1));
      imem_rdata  = $urandom;
      retire      = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_eq("addr_hold", imem_addr, m_pc);
      check_eq("req_hold", {31'd0, imem_req}, 32'd1);
      check_eq("stall_count", retired_count, m_count);
    end
    imem_ready  = 1'b1;
    imem_rvalid = 1'($urandom_range(0, 1));
    imem_rdata  = $urandom;
    retire      = 1'b0;
    @(negedge clk);
    imem_ready = 1'b0;
    check_eq("req_drop", {31'd0, imem_req}, 32'd0);
    for (int i = 0; i < rv_dly; i++) begin
      imem_rvalid = 1'b0;
      retire      = 1'($urandom_range(0, 1));
      imem_ready  = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_eq("wait_valid", {31'd0, instr_valid}, 32'd0);
      check_eq("wait_count", retired_count, m_count);
    end
    imem_ready  = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    retire      = 1'b0;
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    check_eq("instr", instr, word);
    check_eq("instr_valid", {31'd0, instr_valid}, 32'd1);
    check_eq("opcode", {26'd0, opcode}, {26'd0, word[31:26]});
    check_eq("pc", pc, m_pc);
    check_eq("pc_plus4", pc_plus4, m_pc + 32'd4);
    for (int i = 0; i < ex_dly; i++) begin
      branch      = 1'($urandom_range(0, 1));
      jump        = 1'($urandom_range(0, 1));
      zero        = 1'($urandom_range(0, 1));
      imem_rvalid = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_eq("exec_hold", instr, word);
      check_eq("exec_req", {31'd0, imem_req}, 32'd0);
    end
    imem_rvalid = 1'b0;
    retire = 1'b1;
    branch = br;
    jump   = jp;
    zero   = z;
    @(negedge clk);
    retire = 1'b0;
    branch = 1'b0;
    jump   = 1'b0;
    zero   = 1'b0;
    m_count = m_count + 32'd1;
    m_pc    = ref_next(m_pc, word, br, jp, z);
    check_eq("retired_count", retired_count, m_count);
    check_eq("retire_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("next_pc", pc, m_pc);
    check_eq("next_req", {31'd0, imem_req}, 32'd1);
  endtask

  // Jump to the last word of the current 256 MB region, then fall through into the next.
  task automatic cross_region();
    fetch_one(32'h0BFF_FFFF, 1'b0, 1'b1, 1'b0, 0, 0, 0);
    fetch_one(32'h2008_0005, 1'b1, 1'b0, 1'b0, 0, 0, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_eq("rst_req", {31'd0, imem_req}, 32'd0);
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_addr", imem_addr, 32'h0);
    check_eq("rst_count", retired_count, 32'h0);
    check_eq("rst_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("rst_opcode", {26'd0, opcode}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("first_req", {31'd0, imem_req}, 32'd1);
    check_eq("first_addr", imem_addr, 32'h0);

    fetch_one(32'h2008_0005, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    fetch_one(32'h0800_0004, 1'b0, 1'b1, 1'b0, 3, 2, 1);
    fetch_one(32'h1000_FFFE, 1'b1, 1'b0, 1'b1, 0, 0, 0);
    check_eq("beq_taken", m_pc, 32'h0000_000C);
    fetch_one(32'h0800_0004, 1'b0, 1'b1, 1'b0, 1, 1, 0);
    fetch_one(32'h1000_FFFE, 1'b1, 1'b0, 1'b0, 0, 0, 0);
    check_eq("beq_not_taken", m_pc, 32'h0000_0014);

    for (int r = 0; r < 4; r++) cross_region();
    fetch_one(32'h0800_0008, 1'b0, 1'b1, 1'b0, 0, 0, 0);
    check_eq("jump_setup", pc, 32'h4000_0020);
    fetch_one(32'h0800_0040, 1'b1, 1'b1, 1'b1, 0, 1, 0);
    check_eq("jump_prio", imem_addr, 32'h4000_0100);
    for (int r = 0; r < 12; r++) cross_region();
    check_eq("pc_wrap", imem_addr, 32'h0);

    for (int k = 0; k < 40; k++) begin
      fetch_one($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 2),
                $urandom_range(0, 2));
    end

    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_req", {31'd0, imem_req}, 32'd0);
    check_eq("mid_rst_pc", pc, 32'h0);
    check_eq("mid_rst_addr", imem_addr, 32'h0);
    check_eq("mid_rst_instr", instr, 32'h0);
    check_eq("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("mid_rst_count", retired_count, 32'h0);
    retire = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_retire_ign", retired_count, 32'h0);
    check_eq("refetch_addr", imem_addr, 32'h0);
    retire  = 1'b0;
    m_pc    = 32'h0;
    m_count = 32'h0;
    fetch_one(32'h2008_0005, 1'b0, 1'b0, 1'b1, 1, 1, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
